// File: rtl/i2cs_rx_word_packer.sv
// rtl/i2cs_rx_word_packer.sv - I2C-slave RX FIFO drain: packs bytes into 32-bit words
//
// Purpose: pops bytes from the 256x8 receive FIFO, packs them little-endian
// into 32-bit words and offers each word on a valid/ready port. A partial
// word is emitted on flush_i or after cfg_timeout_i idle cycles. A
// registered fill-level interrupt is also produced.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   fifo_pop_o            pop strobe to the FIFO
//   fifo_rd_data_i        FIFO read data (head byte or popped byte, see SHOW_AHEAD)
//   fifo_empty_i          FIFO empty
//   fifo_rd_flags_i       FIFO fill-level code 0..7
//   cfg_timeout_i         idle cycles before partial flush, 0 = disabled
//   cfg_irq_level_i       fill-level interrupt threshold, 0 = disabled
//   flush_i               one-cycle request to emit the current partial word
//   word_valid_o          word available
//   word_ready_i          consumer accepts word
//   word_data_o           packed word, byte n in bits [8n+7:8n]
//   word_bytes_o          valid bytes in word_data_o (1..4)
//   irq_level_o           registered fill-level interrupt
module i2cs_rx_word_packer #(
  parameter bit SHOW_AHEAD = 1'b1,
  parameter int TIMEOUT_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 fifo_pop_o,
  input  logic [7:0]           fifo_rd_data_i,
  input  logic                 fifo_empty_i,
  input  logic [2:0]           fifo_rd_flags_i,
  input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
  input  logic [2:0]           cfg_irq_level_i,
  input  logic                 flush_i,
  output logic                 word_valid_o,
  input  logic                 word_ready_i,
  output logic [31:0]          word_data_o,
  output logic [2:0]           word_bytes_o,
  output logic                 irq_level_o
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic [2:0]           r_count;
  logic [2:0]           w_count_nx;
  logic [3:0][7:0]      r_lanes;
  logic [3:0][7:0]      w_lanes_nx;
  logic [TIMEOUT_W-1:0] r_timer;
  logic [TIMEOUT_W-1:0] w_timer_nx;
  logic                 r_flush_pend;
  logic                 w_flush_pend_nx;
  logic                 r_irq;
  logic                 w_pop;
  logic                 w_valid;

  always_comb begin
    w_state_nx      = r_state;
    w_count_nx      = r_count;
    w_lanes_nx      = r_lanes;
    w_timer_nx      = r_timer;
    w_flush_pend_nx = r_flush_pend;
    w_pop           = 1'b0;

    case (r_state)
      ST_FILL: begin
        w_pop = !fifo_empty_i;
        if (SHOW_AHEAD) begin
          // Head byte is visible now, so the pop edge is also the capture edge.
          if (w_pop) begin
            w_lanes_nx[r_count[1:0]] = fifo_rd_data_i;
            w_count_nx               = r_count + 3'd1;
            w_timer_nx               = '0;
          end
          if (w_count_nx == 3'd4) begin
            w_state_nx = ST_HOLD;
          end else if (flush_i && (w_count_nx != 3'd0)) begin
            w_state_nx = ST_HOLD;
          end else if (!w_pop && (r_count != 3'd0)) begin
            w_timer_nx = r_timer + 1'b1;
            if ((cfg_timeout_i != '0) && (w_timer_nx == cfg_timeout_i)) begin
              w_state_nx = ST_HOLD;
            end
          end
        end else begin
          if (w_pop) begin
            // The byte arrives next cycle; a flush now must wait for it
            // rather than strand the popped byte.
            w_state_nx      = ST_WAIT;
            w_flush_pend_nx = flush_i && (r_count != 3'd0);
          end else if (flush_i && (r_count != 3'd0)) begin
            w_state_nx = ST_HOLD;
          end else if (r_count != 3'd0) begin
            w_timer_nx = r_timer + 1'b1;
            if ((cfg_timeout_i != '0) && (w_timer_nx == cfg_timeout_i)) begin
              w_state_nx = ST_HOLD;
            end
          end
        end
      end

      ST_WAIT: begin
        w_lanes_nx[r_count[1:0]] = fifo_rd_data_i;
        w_count_nx               = r_count + 3'd1;
        w_timer_nx               = '0;
        w_flush_pend_nx          = 1'b0;
        if ((w_count_nx == 3'd4) || r_flush_pend || flush_i) begin
          w_state_nx = ST_HOLD;
        end else begin
          w_state_nx = ST_FILL;
        end
      end

      ST_HOLD: begin
        if (word_ready_i) begin
          w_state_nx      = ST_FILL;
          w_count_nx      = 3'd0;
          w_lanes_nx      = '0;
          w_timer_nx      = '0;
          w_flush_pend_nx = 1'b0;
        end
      end

      default: begin
        w_state_nx = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_FILL;
      r_count      <= 3'd0;
      r_lanes      <= '0;
      r_timer      <= '0;
      r_flush_pend <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_count      <= w_count_nx;
      r_lanes      <= w_lanes_nx;
      r_timer      <= w_timer_nx;
      r_flush_pend <= w_flush_pend_nx;
      r_irq        <= (cfg_irq_level_i != 3'd0) && (fifo_rd_flags_i >= cfg_irq_level_i);
    end
  end

  // The pop is combinational from fifo_empty_i, so reset must gate it directly.
  assign fifo_pop_o   = w_pop && !rst_i;
  assign w_valid      = (r_state == ST_HOLD);
  assign word_valid_o = w_valid;
  assign word_data_o  = w_valid ? r_lanes : 32'd0;
  assign word_bytes_o = w_valid ? r_count : 3'd0;
  assign irq_level_o  = r_irq;

endmodule
